// File: rtl/frame_buffer_ring.sv
// frame_buffer_ring
//   N-way frame store (N = 2 or 3) between a frame writer and a frame reader
//   in one clock domain.
//   3 buffers: write/ready/read roles rotate; the writer never stalls and the
//              reader always takes the newest complete frame.
//   2 buffers: gated ping-pong; the writer is held off (O_wr_ready=0) from
//              commit until the reader takes the frame.
//
// Optional build macro: FRAME_DROP_COUNT_EN
//   defined   -> O_drop_count counts committed frames lost before being read
//                (saturating).
//   undefined -> no counter, O_drop_count is tied to 0.
//
// Ports:
//   I_clk, I_rst_n       clock, asynchronous active-low reset
//   I_wr_en/addr/data    write strobe, word address, word (honoured when O_wr_ready)
//   I_wr_frame_done      pulse: current write buffer holds a complete frame
//   O_wr_ready           writer may write
//   I_rd_en/addr         read strobe, word address
//   O_rd_data/valid      registered read word, valid for one cycle after I_rd_en
//   I_rd_frame_start     pulse: reader starts a frame, takes newest committed one
//   O_frame_pending      committed frame not yet taken by the reader
//   O_data_valid         reader has taken at least one committed frame
//   O_wr_idx/O_rd_idx    buffer currently written / read
//   O_drop_count         committed frames overwritten before being read
module frame_buffer_ring #(
    parameter int BUFFER_COUNT   = 3,
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 4500,
    parameter int ADDR_WIDTH     = $clog2(DEPTH),
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                      I_clk,
    input  logic                      I_rst_n,
    input  logic                      I_wr_en,
    input  logic [ADDR_WIDTH-1:0]     I_wr_addr,
    input  logic [DATA_WIDTH-1:0]     I_wr_data,
    input  logic                      I_wr_frame_done,
    output logic                      O_wr_ready,
    input  logic                      I_rd_en,
    input  logic [ADDR_WIDTH-1:0]     I_rd_addr,
    output logic [DATA_WIDTH-1:0]     O_rd_data,
    output logic                      O_rd_valid,
    input  logic                      I_rd_frame_start,
    output logic                      O_frame_pending,
    output logic                      O_data_valid,
    output logic [1:0]                O_wr_idx,
    output logic [1:0]                O_rd_idx,
    output logic [DROP_CNT_WIDTH-1:0] O_drop_count
);

    localparam int MEM_WORDS = BUFFER_COUNT * DEPTH;
    localparam int MEM_AW    = $clog2(MEM_WORDS);

    generate
        if (BUFFER_COUNT != 2 && BUFFER_COUNT != 3) begin : g_bad_buffer_count
            $error("frame_buffer_ring: BUFFER_COUNT must be 2 or 3");
        end
    endgenerate

    // ---------------------------------------------------------------
    // Role / handshake state
    // ---------------------------------------------------------------
    logic [1:0] wr_idx_reg,    wr_idx_next;
    logic [1:0] rd_idx_reg,    rd_idx_next;
    logic [1:0] ready_idx_reg, ready_idx_next;
    logic       pending_reg,   pending_next;
    logic       data_valid_reg, data_valid_next;
    logic       wr_ready_reg,  wr_ready_next;
    logic       drop_inc;

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            wr_idx_reg     <= 2'd0;
            rd_idx_reg     <= 2'(BUFFER_COUNT - 1);
            ready_idx_reg  <= 2'd1;
            pending_reg    <= 1'b0;
            data_valid_reg <= 1'b0;
            wr_ready_reg   <= 1'b1;
        end else begin
            wr_idx_reg     <= wr_idx_next;
            rd_idx_reg     <= rd_idx_next;
            ready_idx_reg  <= ready_idx_next;
            pending_reg    <= pending_next;
            data_valid_reg <= data_valid_next;
            wr_ready_reg   <= wr_ready_next;
        end
    end

    always_comb begin
        wr_idx_next     = wr_idx_reg;
        rd_idx_next     = rd_idx_reg;
        ready_idx_next  = ready_idx_reg;
        pending_next    = pending_reg;
        data_valid_next = data_valid_reg;
        wr_ready_next   = wr_ready_reg;
        drop_inc        = 1'b0;

        if (BUFFER_COUNT == 3) begin
            wr_ready_next = 1'b1;
            if (I_wr_frame_done && I_rd_frame_start) begin
                // Commit and take at once: the frame just finished goes
                // straight to the reader, the old read buffer becomes spare.
                rd_idx_next     = wr_idx_reg;
                wr_idx_next     = ready_idx_reg;
                ready_idx_next  = rd_idx_reg;
                pending_next    = 1'b0;
                data_valid_next = 1'b1;
                drop_inc        = pending_reg;
            end else if (I_wr_frame_done) begin
                // A still-pending ready frame gets overwritten next: a drop.
                ready_idx_next = wr_idx_reg;
                wr_idx_next    = ready_idx_reg;
                pending_next   = 1'b1;
                drop_inc       = pending_reg;
            end else if (I_rd_frame_start && pending_reg) begin
                rd_idx_next     = ready_idx_reg;
                ready_idx_next  = rd_idx_reg;
                pending_next    = 1'b0;
                data_valid_next = 1'b1;
            end
        end else begin
            // A commit while one is already pending cannot be stored.
            drop_inc = I_wr_frame_done && pending_reg;
            if (I_rd_frame_start && (pending_reg || I_wr_frame_done)) begin
                wr_idx_next     = rd_idx_reg;
                rd_idx_next     = wr_idx_reg;
                pending_next    = 1'b0;
                wr_ready_next   = 1'b1;
                data_valid_next = 1'b1;
            end else if (I_wr_frame_done) begin
                pending_next  = 1'b1;
                wr_ready_next = 1'b0;
            end
        end
    end

    assign O_wr_ready      = wr_ready_reg;
    assign O_frame_pending = pending_reg;
    assign O_data_valid    = data_valid_reg;
    assign O_wr_idx        = wr_idx_reg;
    assign O_rd_idx        = rd_idx_reg;

    // ---------------------------------------------------------------
    // Frame memory: all buffers share one flat array, buffer b occupying
    // words [b*DEPTH, (b+1)*DEPTH).
    // ---------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
    logic [MEM_AW-1:0]     wr_lin;
    logic [MEM_AW-1:0]     rd_lin;
    logic                  wr_in_range;
    logic                  rd_in_range;
    logic [DATA_WIDTH-1:0] rd_data_reg;
    logic                  rd_valid_reg;

    assign wr_in_range = (32'(I_wr_addr) < DEPTH);
    assign rd_in_range = (32'(I_rd_addr) < DEPTH);
    assign wr_lin = MEM_AW'(wr_idx_reg) * MEM_AW'(DEPTH) + MEM_AW'(I_wr_addr);
    assign rd_lin = MEM_AW'(rd_idx_reg) * MEM_AW'(DEPTH) + MEM_AW'(I_rd_addr);

    always_ff @(posedge I_clk) begin
        if (I_wr_en && wr_ready_reg && wr_in_range) begin
            mem[wr_lin] <= I_wr_data;
        end
    end

    // Read uses the index held before any same-cycle frame start.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= I_rd_en;
            if (I_rd_en) begin
                rd_data_reg <= rd_in_range ? mem[rd_lin] : '0;
            end
        end
    end

    assign O_rd_data  = rd_data_reg;
    assign O_rd_valid = rd_valid_reg;

    // ---------------------------------------------------------------
    // Dropped-frame counter (saturating)
    // ---------------------------------------------------------------
`ifdef FRAME_DROP_COUNT_EN
    logic [DROP_CNT_WIDTH-1:0] drop_count_reg;

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            drop_count_reg <= '0;
        end else if (drop_inc && (drop_count_reg != '1)) begin
            drop_count_reg <= drop_count_reg + DROP_CNT_WIDTH'(1);
        end
    end

    assign O_drop_count = drop_count_reg;
`else
    logic unused_drop_inc;
    assign unused_drop_inc = drop_inc;
    assign O_drop_count    = '0;
`endif

endmodule

// File: tb/tb_frame_buffer_ring.sv
// Testbench for frame_buffer_ring. A 3-buffer and a 2-buffer instance share
// one stimulus stream; each is compared every cycle against a behavioural
// model of buffer roles and frame contents.
module tb_frame_buffer_ring;

    localparam int DW    = 32;
    localparam int DEPTH = 48;
    localparam int AW    = $clog2(DEPTH);
    localparam int DCW   = 16;
`ifdef FRAME_DROP_COUNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          rd_start;

    logic           wr_ready_o [2];
    logic [DW-1:0]  rd_data_o  [2];
    logic           rd_valid_o [2];
    logic           pend_o     [2];
    logic           dv_o       [2];
    logic [1:0]     wr_idx_o   [2];
    logic [1:0]     rd_idx_o   [2];
    logic [DCW-1:0] drop_o     [2];

    always #5 clk = ~clk;

    frame_buffer_ring #(
        .BUFFER_COUNT(3), .DATA_WIDTH(DW), .DEPTH(DEPTH),
        .ADDR_WIDTH(AW), .DROP_CNT_WIDTH(DCW)
    ) dut3 (
        .I_clk(clk), .I_rst_n(rst_n),
        .I_wr_en(wr_en), .I_wr_addr(wr_addr), .I_wr_data(wr_data),
        .I_wr_frame_done(wr_done), .O_wr_ready(wr_ready_o[0]),
        .I_rd_en(rd_en), .I_rd_addr(rd_addr),
        .O_rd_data(rd_data_o[0]), .O_rd_valid(rd_valid_o[0]),
        .I_rd_frame_start(rd_start), .O_frame_pending(pend_o[0]),
        .O_data_valid(dv_o[0]), .O_wr_idx(wr_idx_o[0]), .O_rd_idx(rd_idx_o[0]),
        .O_drop_count(drop_o[0])
    );

    frame_buffer_ring #(
        .BUFFER_COUNT(2), .DATA_WIDTH(DW), .DEPTH(DEPTH),
        .ADDR_WIDTH(AW), .DROP_CNT_WIDTH(DCW)
    ) dut2 (
        .I_clk(clk), .I_rst_n(rst_n),
        .I_wr_en(wr_en), .I_wr_addr(wr_addr), .I_wr_data(wr_data),
        .I_wr_frame_done(wr_done), .O_wr_ready(wr_ready_o[1]),
        .I_rd_en(rd_en), .I_rd_addr(rd_addr),
        .O_rd_data(rd_data_o[1]), .O_rd_valid(rd_valid_o[1]),
        .I_rd_frame_start(rd_start), .O_frame_pending(pend_o[1]),
        .O_data_valid(dv_o[1]), .O_wr_idx(wr_idx_o[1]), .O_rd_idx(rd_idx_o[1]),
        .O_drop_count(drop_o[1])
    );

    // ---------------- reference model ----------------
    int          nbuf [2] = '{3, 2};
    int          wi [2], ri [2], yi [2], drops [2];
    bit          pend [2], dv [2], wrdy [2], rval [2], rknown [2];
    logic [31:0] rdat [2];
    logic [31:0] mem   [2][3][64];
    bit          known [2][3][64];

    int vectors     = 0;
    int miscompares = 0;

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            wi[k] = 0; ri[k] = nbuf[k] - 1; yi[k] = 1; drops[k] = 0;
            pend[k] = 0; dv[k] = 0; wrdy[k] = 1; rval[k] = 0;
            rdat[k] = 32'd0; rknown[k] = 1;
            for (int b = 0; b < 3; b++)
                for (int a = 0; a < 64; a++) known[k][b][a] = 0;
        end
    endfunction

    function automatic void bump_drop(int k);
        if (drops[k] < 65535) drops[k]++;
    endfunction

    // A same-cycle commit+take is modelled as the commit followed by the take.
    function automatic void model_edge(int k);
        int t;
        if (rd_en) begin
            rval[k] = 1;
            if (int'(rd_addr) < DEPTH) begin
                rdat[k]   = mem[k][ri[k]][rd_addr];
                rknown[k] = known[k][ri[k]][rd_addr];
            end else begin
                rdat[k] = 32'd0; rknown[k] = 1;
            end
        end else begin
            rval[k] = 0;
        end
        if (wr_en && wrdy[k] && int'(wr_addr) < DEPTH) begin
            mem[k][wi[k]][wr_addr]   = wr_data;
            known[k][wi[k]][wr_addr] = 1;
        end
        if (wr_done) begin
            if (nbuf[k] == 3) begin
                if (pend[k]) bump_drop(k);
                t = wi[k]; wi[k] = yi[k]; yi[k] = t;
                pend[k] = 1;
            end else if (pend[k]) begin
                bump_drop(k);
            end else begin
                pend[k] = 1; wrdy[k] = 0;
            end
        end
        if (rd_start && pend[k]) begin
            if (nbuf[k] == 3) begin
                t = ri[k]; ri[k] = yi[k]; yi[k] = t;
            end else begin
                t = ri[k]; ri[k] = wi[k]; wi[k] = t;
            end
            wrdy[k] = 1; pend[k] = 0; dv[k] = 1;
        end
    endfunction

    function automatic int exp_drop(int k);
        return DROP_EN ? drops[k] : 0;
    endfunction

    function automatic void chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endfunction

    function automatic void check_all();
        for (int k = 0; k < 2; k++) begin
            string n;
            n = (k == 0) ? "n3" : "n2";
            chk({n, "_wr_idx"},   64'(wr_idx_o[k]),   64'(wi[k]));
            chk({n, "_rd_idx"},   64'(rd_idx_o[k]),   64'(ri[k]));
            chk({n, "_wr_ready"}, 64'(wr_ready_o[k]), 64'(wrdy[k]));
            chk({n, "_pending"},  64'(pend_o[k]),     64'(pend[k]));
            chk({n, "_data_vld"}, 64'(dv_o[k]),       64'(dv[k]));
            chk({n, "_rd_valid"}, 64'(rd_valid_o[k]), 64'(rval[k]));
            chk({n, "_drop"},     64'(drop_o[k]),     64'(exp_drop(k)));
            if (rknown[k]) chk({n, "_rd_data"}, 64'(rd_data_o[k]), 64'(rdat[k]));
        end
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check_all();
    endtask

    task automatic idle();
        wr_en = 0; wr_addr = '0; wr_data = '0; wr_done = 0;
        rd_en = 0; rd_addr = '0; rd_start = 0;
    endtask

    task automatic write_frame(input int n, input int base);
        for (int a = 0; a < n; a++) begin
            wr_en = 1; wr_addr = AW'(a); wr_data = 32'(base + a);
            cycle();
        end
        wr_en = 0;
    endtask

    task automatic pulse_done();
        wr_done = 1; cycle(); wr_done = 0;
    endtask

    task automatic pulse_start();
        rd_start = 1; cycle(); rd_start = 0;
    endtask

    task automatic read_word(input int a);
        rd_en = 1; rd_addr = AW'(a); cycle(); rd_en = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    initial begin
        int prev_wr;
        idle();
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("reset_wr_idx",   64'(wr_idx_o[0]),   64'd0);
        chk("reset_rd_idx",   64'(rd_idx_o[0]),   64'd2);
        chk("reset_wr_ready", 64'(wr_ready_o[0]), 64'd1);
        chk("reset_data_vld", 64'(dv_o[0]),       64'd0);
        chk("reset_rd_valid", 64'(rd_valid_o[0]), 64'd0);
        rst_n = 1;

        // basic flow: frame A (data = addr) into buffer 0, commit, take
        write_frame(DEPTH, 0);
        pulse_done();
        pulse_start();
        chk("basic_rd_idx",   64'(rd_idx_o[0]), 64'd0);
        chk("basic_wr_idx",   64'(wr_idx_o[0]), 64'd1);
        chk("basic_data_vld", 64'(dv_o[0]),     64'd1);
        read_word(5);
        chk("basic_rd_data",  64'(rd_data_o[0]),  64'd5);
        chk("basic_rd_valid", 64'(rd_valid_o[0]), 64'd1);
        cycle();
        read_word(DEPTH + 3);
        chk("oob_rd_data", 64'(rd_data_o[0]), 64'd0);

        // overrun: two commits without a take
        write_frame(8, 100);
        pulse_done();
        write_frame(8, 200);
        pulse_done();
        chk("overrun_drop", 64'(drop_o[0]), DROP_EN ? 64'd1 : 64'd0);
        pulse_start();
        read_word(5);
        chk("overrun_newest", 64'(rd_data_o[0]), 64'd205);
        chk("overrun_2buf_oldest", 64'(rd_data_o[1]), 64'd105);
        pulse_start();
        chk("repeat_rd_idx", 64'(rd_idx_o[0]), 64'd2);

        // simultaneous commit + take with a frame already pending
        write_frame(4, 300);
        pulse_done();
        write_frame(4, 400);
        prev_wr = wi[0];
        wr_done = 1; rd_start = 1; cycle(); wr_done = 0; rd_start = 0;
        chk("simul_rd_idx",  64'(rd_idx_o[0]), 64'(prev_wr));
        chk("simul_pending", 64'(pend_o[0]),   64'd0);
        read_word(2);
        chk("simul_rd_data", 64'(rd_data_o[0]), 64'd402);

        // back-pressure in 2-buffer mode
        write_frame(1, 32'h1111_1111);
        pulse_done();
        chk("bp_wr_ready_low", 64'(wr_ready_o[1]), 64'd0);
        wr_en = 1; wr_addr = '0; wr_data = 32'hDEAD_BEEF; cycle(); wr_en = 0;
        pulse_start();
        chk("bp_wr_ready_high", 64'(wr_ready_o[1]), 64'd1);
        read_word(0);
        chk("bp_2buf_data", 64'(rd_data_o[1]), 64'h1111_1111);
        chk("bp_3buf_data", 64'(rd_data_o[0]), 64'h1111_1111);

        // reset mid-frame with a frame pending and reads in flight
        write_frame(4, 500);
        pulse_done();
        rd_en = 1; rd_addr = AW'(1); cycle();
        do_reset();
        idle();
        chk("midrst_rd_valid", 64'(rd_valid_o[0]), 64'd0);
        chk("midrst_pending",  64'(pend_o[0]),     64'd0);
        pulse_start();
        chk("midrst_rd_idx3", 64'(rd_idx_o[0]), 64'd2);
        chk("midrst_rd_idx2", 64'(rd_idx_o[1]), 64'd1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            wr_en    = ($urandom_range(0, 3) != 0);
            wr_addr  = AW'($urandom_range(0, 63));
            wr_data  = $urandom;
            wr_done  = ($urandom_range(0, 9) == 0);
            rd_en    = ($urandom_range(0, 1) != 0);
            rd_addr  = AW'($urandom_range(0, 63));
            rd_start = ($urandom_range(0, 9) == 0);
            cycle();
            if (i == 300) do_reset();
        end
        idle();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
